// File: rtl/mux_rr_arbiter_if.sv
// Requester/consumer bus of the 32:1 mux round-robin arbiter.
// The arbiter side drives the mux select and one-hot grant.
interface mux_rr_arbiter_if;
  localparam int unsigned NREQ  = 32;
  localparam int unsigned SEL_W = 5;

  logic [NREQ-1:0]  req;
  logic             out_ready;
  logic [SEL_W-1:0] sel;
  logic [NREQ-1:0]  grant;
  logic             out_valid;
  logic             busy;

  modport master (
    input  req, out_ready,
    output sel, grant, out_valid, busy
  );

  modport slave (
    output req, out_ready,
    input  sel, grant, out_valid, busy
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 32:1 datapath mux among 32 requesters.
// The selection is held under backpressure; one transfer per clock at most.
module mux_rr_arbiter (
  input  logic              clk,
  input  logic              rst,
  mux_rr_arbiter_if.master  bus
);
  localparam int unsigned NREQ  = 32;
  localparam int unsigned SEL_W = 5;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic             valid_q, valid_d;

  logic             xfer_c;
  logic [SEL_W-1:0] base_c;
  logic             hit_c;
  logic [SEL_W-1:0] pick_c;

  // First set request bit scanning upward from base, wrapping at NREQ.
  function automatic logic [SEL_W:0] rr_pick(input logic [NREQ-1:0]  r,
                                             input logic [SEL_W-1:0] base);
    logic             hit;
    logic [SEL_W-1:0] res;
    logic [SEL_W-1:0] idx;
    hit = 1'b0;
    res = base;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = base + SEL_W'(i);
      if (!hit && r[idx]) begin
        hit = 1'b1;
        res = idx;
      end
    end
    return {hit, res};
  endfunction

  // In GRANT the pick is only consumed on a transfer, where the new ptr is sel+1.
  assign xfer_c          = valid_q && bus.out_ready;
  assign base_c          = (state_q == GRANT) ? SEL_W'(sel_q + SEL_W'(1)) : ptr_q;
  assign {hit_c, pick_c} = rr_pick(bus.req, base_c);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (hit_c) begin
          sel_d   = pick_c;
          grant_d = NREQ'(1) << pick_c;
          valid_d = 1'b1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (xfer_c) begin
          ptr_d = base_c;
          if (hit_c) begin
            sel_d   = pick_c;
            grant_d = NREQ'(1) << pick_c;
          end else begin
            grant_d = '0;
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        grant_d = '0;
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.grant     = grant_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = valid_q;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_mux_rr_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;

  mux_rr_arbiter_if bus();
  mux_rr_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model state: expected valid/sel and next-pick priority pointer.
  bit m_valid = 1'b0;
  int m_sel   = 0;
  int m_ptr   = 0;

  function automatic int first_from(input logic [31:0] r, input int p);
    for (int k = 0; k < 32; k++)
      if (r[(p + k) % 32]) return (p + k) % 32;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b0;
      m_sel   = 0;
      m_ptr   = 0;
    end else if (!m_valid) begin
      if (bus.req != 32'h0) begin
        m_sel   = first_from(bus.req, m_ptr);
        m_valid = 1'b1;
      end
    end else if (bus.out_ready) begin
      m_ptr = (m_sel + 1) % 32;
      if (bus.req != 32'h0) m_sel = first_from(bus.req, m_ptr);
      else m_valid = 1'b0;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    logic [31:0] exp_g;
    if (chk_en) begin
      exp_g = m_valid ? (32'h1 << m_sel) : 32'h0;
      checks += 4;
      if (bus.out_valid !== m_valid) begin
        errors++;
        $display("FAIL model_valid t=%0t got %b want %b", $time, bus.out_valid, m_valid);
      end
      if (bus.sel !== 5'(m_sel)) begin
        errors++;
        $display("FAIL model_sel t=%0t got %0d want %0d", $time, bus.sel, m_sel);
      end
      if (bus.grant !== exp_g) begin
        errors++;
        $display("FAIL model_grant t=%0t got %h want %h", $time, bus.grant, exp_g);
      end
      if (bus.busy !== m_valid) begin
        errors++;
        $display("FAIL model_busy t=%0t got %b want %b", $time, bus.busy, m_valid);
      end
    end
  end

  // Apply inputs at a falling edge and return at the next falling edge.
  task automatic step(input logic [31:0] r, input bit rdy);
    bus.req       = r;
    bus.out_ready = rdy;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(32'h0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic lit(input string name, input bit v, input int s);
    logic [31:0] g;
    g = v ? (32'h1 << s) : 32'h0;
    checks += 3;
    if (bus.out_valid !== v) begin
      errors++;
      $display("FAIL %s valid got %b want %b", name, bus.out_valid, v);
    end
    if (bus.sel !== 5'(s)) begin
      errors++;
      $display("FAIL %s sel got %0d want %0d", name, bus.sel, s);
    end
    if (bus.grant !== g) begin
      errors++;
      $display("FAIL %s grant got %h want %h", name, bus.grant, g);
    end
  endtask

  initial begin
    logic [31:0] r;
    bus.req       = 32'h0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    do_reset();
    chk_en = 1'b1;
    lit("reset", 1'b0, 0);

    // Single requester, then drop after the transfer.
    step(32'h1, 1'b1);             lit("t1_grant", 1'b1, 0);
    step(32'h0, 1'b1);             lit("t1_idle", 1'b0, 0);

    // All requesting: strict rotation 0..31 then 0, no bubbles.
    do_reset();
    for (int i = 0; i <= 32; i++) begin
      step(32'hFFFF_FFFF, 1'b1);
      lit("t2_rotate", 1'b1, i % 32);
    end

    // Wrap after serving 31.
    do_reset();
    step(32'h8000_0000, 1'b1);     lit("t3_sel31", 1'b1, 31);
    step(32'h4000_0001, 1'b1);     lit("t3_sel0", 1'b1, 0);
    step(32'h4000_0001, 1'b1);     lit("t3_sel30", 1'b1, 30);
    step(32'h0, 1'b1);             lit("t3_idle", 1'b0, 30);

    // ptr=4 with requests 3 and 5.
    do_reset();
    step(32'h0000_0008, 1'b1);     lit("t4_sel3", 1'b1, 3);
    step(32'h0000_0028, 1'b1);     lit("t4_sel5", 1'b1, 5);
    step(32'h0000_0028, 1'b1);     lit("t4_sel3b", 1'b1, 3);
    step(32'h0, 1'b1);             lit("t4_idle", 1'b0, 3);

    // Backpressure hold with requester drop.
    do_reset();
    step(32'h0000_0080, 1'b0);     lit("t5_sel7", 1'b1, 7);
    for (int i = 0; i < 5; i++) begin
      step(32'h0000_0004, 1'b0);   lit("t5_hold", 1'b1, 7);
    end
    step(32'h0000_0004, 1'b1);     lit("t5_sel2", 1'b1, 2);
    step(32'h0, 1'b1);             lit("t5_idle", 1'b0, 2);

    // Reset in GRANT.
    do_reset();
    step(32'h0000_0200, 1'b0);     lit("t6_sel9", 1'b1, 9);
    rst = 1'b1;
    step(32'hFFFF_FFFF, 1'b1);     lit("t6_rst", 1'b0, 0);
    rst = 1'b0;
    step(32'hFFFF_FFFF, 1'b1);     lit("t6_first", 1'b1, 0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(0, 5))
        0: r = 32'h0;
        1: r = 32'h1 << $urandom_range(0, 31);
        2: r = 32'hFFFF_FFFF;
        3: r = $urandom;
        default: r = $urandom & $urandom & $urandom;
      endcase
      rst = ($urandom_range(0, 99) == 0);
      step(r, $urandom_range(0, 3) != 0);
    end
    rst = 1'b0;
    step(32'h0, 1'b1);
    step(32'h0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
